// File: rtl/gate_pkg.sv
// Shared definitions for the registered wide-gate unit: op encoding and
// the reference bitwise function used by the datapath.
package gate_pkg;

    localparam int unsigned MAX_W = 64;

    typedef enum logic [2:0] {
        OP_AND   = 3'd0,
        OP_OR    = 3'd1,
        OP_NAND  = 3'd2,
        OP_NOR   = 3'd3,
        OP_XOR   = 3'd4,
        OP_XNOR  = 3'd5,
        OP_NOTA  = 3'd6,
        OP_PASSA = 3'd7
    } op_e;

    // Operates on the widest legal word; callers truncate to their own WIDTH.
    function automatic logic [MAX_W-1:0] gate_apply(
        input op_e              op,
        input logic [MAX_W-1:0] a,
        input logic [MAX_W-1:0] b
    );
        logic [MAX_W-1:0] r;
        case (op)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_NAND:  r = ~(a & b);
            OP_NOR:   r = ~(a | b);
            OP_XOR:   r = a ^ b;
            OP_XNOR:  r = ~(a ^ b);
            OP_NOTA:  r = ~a;
            OP_PASSA: r = a;
            default:  r = a;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/gate_array_pipe_if.sv
// Operand/result handshake bundle of gate_array_pipe, plus its status outputs.
interface gate_array_pipe_if #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zr;
    logic             out_ng;
    logic             out_par;
    logic [CNT_W-1:0] txn_count;

    modport master (
        output in_valid, in_op, in_a, in_b, out_ready,
        input  in_ready, out_valid, out_data, out_zr, out_ng, out_par, txn_count
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, out_ready,
        output in_ready, out_valid, out_data, out_zr, out_ng, out_par, txn_count
    );
endinterface

// File: rtl/gate_flags.sv
// Combinational zero / negative / parity status of a word; shared with the ALU.
module gate_flags #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] data_i,
    output logic             zr_o,
    output logic             ng_o,
    output logic             par_o
);

    // Status flags derived directly from the word.
    always_comb begin
        zr_o  = ~|data_i;
        ng_o  = data_i[WIDTH-1];
        par_o = ^data_i;
    end

endmodule

// File: rtl/gate_array_pipe.sv
// Two-stage valid/ready pipeline applying a bitwise gate to two WIDTH-bit
// operands, with registered status flags and a saturating transfer counter.
module gate_array_pipe
    import gate_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic            clk,
    input  logic            reset,
    gate_array_pipe_if.slave bus
);

    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_data_q, s1_data_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic             zr_q, zr_d;
    logic             ng_q, ng_d;
    logic             par_q, par_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_free_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    logic [WIDTH-1:0] gate_res_s;
    logic             flag_zr_s;
    logic             flag_ng_s;
    logic             flag_par_s;

    gate_flags #(.WIDTH(WIDTH)) u_flags (
        .data_i (s1_data_q),
        .zr_o   (flag_zr_s),
        .ng_o   (flag_ng_s),
        .par_o  (flag_par_s)
    );

    // Handshake qualifiers; in_ready deliberately looks through to out_ready.
    always_comb begin
        s2_free_s  = !out_valid_q || bus.out_ready;
        s1_adv_s   = s1_valid_q && s2_free_s;
        in_ready_s = !s1_valid_q || s2_free_s;
        in_xfer_s  = bus.in_valid && in_ready_s;
        out_xfer_s = out_valid_q && bus.out_ready;
        gate_res_s = WIDTH'(gate_apply(op_e'(bus.in_op), MAX_W'(bus.in_a), MAX_W'(bus.in_b)));
    end

    // Next-state for both stages and the counter.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_data_d   = s1_data_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        zr_d        = zr_q;
        ng_d        = ng_q;
        par_d       = par_q;
        cnt_d       = cnt_q;

        if (in_xfer_s) begin
            s1_valid_d = 1'b1;
            s1_data_d  = gate_res_s;
        end else if (s1_adv_s) begin
            s1_valid_d = 1'b0;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        // Flags travel with the data so they stay coherent during a stall.
        if (s1_adv_s) begin
            out_valid_d = 1'b1;
            out_data_d  = s1_data_q;
            zr_d        = flag_zr_s;
            ng_d        = flag_ng_s;
            par_d       = flag_par_s;
        end else if (bus.out_ready) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end

        if (out_xfer_s && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // State registers with synchronous reset that discards in-flight beats.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s1_data_q   <= {WIDTH{1'b0}};
            out_valid_q <= 1'b0;
            out_data_q  <= {WIDTH{1'b0}};
            zr_q        <= 1'b0;
            ng_q        <= 1'b0;
            par_q       <= 1'b0;
            cnt_q       <= {CNT_W{1'b0}};
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_data_q   <= s1_data_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            zr_q        <= zr_d;
            ng_q        <= ng_d;
            par_q       <= par_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_zr    = zr_q;
    assign bus.out_ng    = ng_q;
    assign bus.out_par   = par_q;
    assign bus.txn_count = cnt_q;

endmodule

// File: tb/tb_gate_array_pipe.sv
// Directed scoreboard bench for gate_array_pipe (main instance plus a
// narrow-counter instance for saturation).
module tb_gate_array_pipe;
    import gate_pkg::*;

    typedef struct {
        logic [15:0] d;
        logic        zr;
        logic        ng;
        logic        par;
        int          stamp;
    } exp_t;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   waits    = 0;
    bit   chk_lat  = 1'b0;
    exp_t sb[$];

    gate_array_pipe_if #(.WIDTH(16), .CNT_W(16)) bus ();
    gate_array_pipe_if #(.WIDTH(16), .CNT_W(3))  sbus ();

    gate_array_pipe #(.WIDTH(16), .CNT_W(16)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus.slave)
    );

    gate_array_pipe #(.WIDTH(16), .CNT_W(3)) dut_sat (
        .clk   (clk),
        .reset (rst),
        .bus   (sbus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [15:0] model(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return ~(a & b);
            3'd3:    return ~(a | b);
            3'd4:    return a ^ b;
            3'd5:    return ~(a ^ b);
            3'd6:    return ~a;
            default: return a;
        endcase
    endfunction

    function automatic exp_t mk(input logic [15:0] d);
        exp_t e;
        e.d = d; e.zr = (d == 16'h0000); e.ng = d[15]; e.par = ^d; e.stamp = 0;
        return e;
    endfunction

    function automatic exp_t mke(input logic [15:0] d, input logic zr, input logic ng, input logic par);
        exp_t e;
        e.d = d; e.zr = zr; e.ng = ng; e.par = par; e.stamp = 0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b, input exp_t e);
        int w;
        bus.in_valid = 1'b1;
        bus.in_op    = op;
        bus.in_a     = a;
        bus.in_b     = b;
        w = 0;
        @(negedge clk);
        while (!bus.in_ready && w < 40) begin
            w++;
            waits++;
            @(negedge clk);
        end
        chk("send_accept", {31'd0, bus.in_ready}, 32'd1);
        if (bus.in_ready === 1'b1) begin
            e.stamp = cyc;
            sb.push_back(e);
        end
        step();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int w;
        w = 0;
        @(negedge clk);
        while ((sb.size() != 0 || bus.out_valid) && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("drain_empty", sb.size(), 32'd0);
        step();
    endtask

    // Output monitor: pops the scoreboard on every output transfer.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
        end else if (bus.out_valid && bus.out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                failures++;
                $error("FAIL sb_unexpected got=%h exp=none", bus.out_data);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("out_data", bus.out_data, e.d);
                chk("out_zr", bus.out_zr, e.zr);
                chk("out_ng", bus.out_ng, e.ng);
                chk("out_par", bus.out_par, e.par);
                if (chk_lat) chk("latency", cyc - e.stamp, 32'd2);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] sweep_exp [8];
        logic [15:0] first_d;
        logic [2:0]  op;
        logic [15:0] a, b;
        int          idx, w0, sat_exp;

        sweep_exp[0] = 16'hF000; sweep_exp[1] = 16'hFFF0; sweep_exp[2] = 16'h0FFF;
        sweep_exp[3] = 16'h000F; sweep_exp[4] = 16'h0FF0; sweep_exp[5] = 16'hF00F;
        sweep_exp[6] = 16'h0F0F; sweep_exp[7] = 16'hF0F0;

        bus.in_valid = 1'b0; bus.in_op = 3'd0; bus.in_a = 16'h0; bus.in_b = 16'h0; bus.out_ready = 1'b0;
        sbus.in_valid = 1'b0; sbus.in_op = 3'd1; sbus.in_a = 16'h1234; sbus.in_b = 16'h0001; sbus.out_ready = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_out_data", bus.out_data, 32'd0);
        chk("rst_flags", {29'd0, bus.out_zr, bus.out_ng, bus.out_par}, 32'd0);
        chk("rst_txn", bus.txn_count, 32'd0);
        chk("rst_in_ready", {31'd0, bus.in_ready}, 32'd1);
        step();

        // Op sweep, back-to-back with fixed latency
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        for (int i = 0; i < 8; i++) begin
            op = 3'(i);
            send(op, 16'hF0F0, 16'hFF00, mk(sweep_exp[i]));
        end
        wait_drain();
        chk("sweep_txn", bus.txn_count, 32'd8);

        // Zero / negative flags
        send(3'd3, 16'hFFFF, 16'hFFFF, mke(16'h0000, 1'b1, 1'b0, 1'b0));
        send(3'd7, 16'h8001, 16'h5555, mke(16'h8001, 1'b0, 1'b1, 1'b0));
        wait_drain();
        chk("flags_txn", bus.txn_count, 32'd10);

        // Backpressure: consumer stalled for the first four cycles
        chk_lat = 1'b0;
        idx = 0;
        first_d = model(3'd4, 16'h1000, 16'h00FF);
        for (int k = 0; k < 30 && idx < 5; k++) begin
            bus.out_ready = (k >= 4);
            bus.in_valid  = 1'b1;
            bus.in_op     = 3'd4;
            bus.in_a      = 16'h1000 + 16'(idx);
            bus.in_b      = 16'h00FF;
            @(negedge clk);
            if (k == 2 || k == 3) begin
                chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
                chk("bp_hold_data", bus.out_data, first_d);
                chk("bp_hold_valid", {31'd0, bus.out_valid}, 32'd1);
            end
            if (bus.in_ready) begin
                sb.push_back(mk(model(3'd4, 16'h1000 + 16'(idx), 16'h00FF)));
                idx++;
            end
            step();
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        wait_drain();
        chk("bp_txn", bus.txn_count, 32'd15);

        // Simultaneous accept and drain
        w0 = waits;
        chk_lat = 1'b1;
        for (int i = 0; i < 10; i++) begin
            op = 3'($urandom_range(7, 0));
            a  = 16'($urandom);
            b  = 16'($urandom);
            send(op, a, b, mk(model(op, a, b)));
        end
        chk("stream_no_stall", waits - w0, 32'd0);
        wait_drain();
        chk("stream_txn", bus.txn_count, 32'd25);

        // Reset with two beats in flight
        bus.out_ready = 1'b0;
        chk_lat = 1'b0;
        send(3'd1, 16'h00AA, 16'h5500, mk(16'h55AA));
        send(3'd0, 16'hFFFF, 16'h1234, mk(16'h1234));
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("mid_rst_txn", bus.txn_count, 32'd0);
        chk("mid_rst_data", bus.out_data, 32'd0);
        step();
        bus.out_ready = 1'b1;
        chk_lat = 1'b1;
        send(3'd5, 16'h0F0F, 16'h00FF, mk(16'hF00F));
        wait_drain();
        chk("post_rst_txn", bus.txn_count, 32'd1);

        // Counter saturation on the 3-bit instance
        sbus.in_valid = 1'b1;
        sbus.out_ready = 1'b1;
        sat_exp = 0;
        for (int k = 0; k < 14; k++) begin
            @(negedge clk);
            chk("sat_count", sbus.txn_count, sat_exp);
            if (sbus.out_valid && sbus.out_ready && sat_exp < 7) sat_exp++;
            step();
        end
        sbus.in_valid = 1'b0;
        @(negedge clk);
        chk("sat_hold", sbus.txn_count, 32'd7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
